// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NREAD registered read ports, hardwired r0, pending scoreboard.
// Latency: read data, valid and pending status appear 1 cycle after re; REGFILE_BYPASS_EN forwards same-edge writes.
// Backpressure: none; every port accepts one request per cycle unconditionally.
module regfile_mp #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NREAD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD-1:0]      re,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*DW-1:0]   rd,
    output logic [NREAD-1:0]      rd_valid,
    output logic [NREAD-1:0]      rd_pend,
    input  logic                  wea,
    input  logic [AW-1:0]         waa,
    input  logic [DW-1:0]         wda,
    input  logic                  web,
    input  logic [AW-1:0]         wab,
    input  logic [DW-1:0]         wdb,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    output logic [(1<<AW)-1:0]    pend
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_nxt;

    logic wr_a_ok;
    logic wr_b_ok;
    logic rsv_ok;

    assign wr_a_ok = wea && (waa != '0);
    assign wr_b_ok = web && (wab != '0);
    assign rsv_ok  = rsv_en && (rsv_addr != '0);

    // Reserve is applied last: it belongs to a newer producer than any same-cycle writeback.
    always_comb begin
        pend_nxt = pend_q;
        if (wr_a_ok) begin
            pend_nxt[waa] = 1'b0;
        end
        if (wr_b_ok) begin
            pend_nxt[wab] = 1'b0;
        end
        if (rsv_ok) begin
            pend_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    assign pend = pend_q;

    // Port B is assigned second so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            if (wr_a_ok) begin
                mem[waa] <= wda;
            end
            if (wr_b_ok) begin
                mem[wab] <= wdb;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          pbit;
        logic [DW-1:0] rd_r;
        logic          pd_r;
        logic          vld_r;

        assign addr = ra[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        logic hit_a;
        logic hit_b;

        assign hit_a = wr_a_ok && (waa == addr);
        assign hit_b = wr_b_ok && (wab == addr);

        always_comb begin
            data = mem[addr];
            if (hit_b) begin
                data = wdb;
            end else if (hit_a) begin
                data = wda;
            end
        end

        assign pbit = pend_nxt[addr];
`else
        assign data = mem[addr];
        assign pbit = pend_q[addr];
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_r  <= '0;
                pd_r  <= 1'b0;
                vld_r <= 1'b0;
            end else begin
                vld_r <= re[i];
                if (re[i]) begin
                    rd_r <= data;
                    pd_r <= pbit;
                end
            end
        end

        assign rd[i*DW +: DW] = rd_r;
        assign rd_pend[i]     = pd_r;
        assign rd_valid[i]    = vld_r;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with four read ports: vector table plus reset-clear sequence.
module tb_regfile_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREAD = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NREAD-1:0]    re;
    logic [NREAD*AW-1:0] ra;
    logic [NREAD*DW-1:0] rd;
    logic [NREAD-1:0]    rd_valid;
    logic [NREAD-1:0]    rd_pend;
    logic                wea;
    logic [AW-1:0]       waa;
    logic [DW-1:0]       wda;
    logic                web;
    logic [AW-1:0]       wab;
    logic [DW-1:0]       wdb;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [31:0]         pend;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.AW(AW), .DW(DW), .NREAD(NREAD)) dut (
        .clk      (clk),
        .rst      (rst),
        .re       (re),
        .ra       (ra),
        .rd       (rd),
        .rd_valid (rd_valid),
        .rd_pend  (rd_pend),
        .wea      (wea),
        .waa      (waa),
        .wda      (wda),
        .web      (web),
        .wab      (wab),
        .wdb      (wdb),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   re;
        logic [19:0]  ra;
        logic         wea;
        logic [4:0]   waa;
        logic [31:0]  wda;
        logic         web;
        logic [4:0]   wab;
        logic [31:0]  wdb;
        logic         rsv_en;
        logic [4:0]   rsv_addr;
        logic [3:0]   x_vld;
        logic [127:0] x_rd;
        logic [3:0]   x_pd;
        logic [31:0]  x_pend;
    } vec_t;

    function automatic vec_t mk(
        input logic [3:0] re_i, input logic [19:0] ra_i,
        input logic wea_i, input logic [4:0] waa_i, input logic [31:0] wda_i,
        input logic web_i, input logic [4:0] wab_i, input logic [31:0] wdb_i,
        input logic rsv_i, input logic [4:0] rsva_i,
        input logic [3:0] xv, input logic [127:0] xr, input logic [3:0] xp, input logic [31:0] xpe);
        vec_t v;
        v.re = re_i;   v.ra = ra_i;
        v.wea = wea_i; v.waa = waa_i; v.wda = wda_i;
        v.web = web_i; v.wab = wab_i; v.wdb = wdb_i;
        v.rsv_en = rsv_i; v.rsv_addr = rsva_i;
        v.x_vld = xv; v.x_rd = xr; v.x_pd = xp; v.x_pend = xpe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        re = '0; ra = '0;
        wea = 1'b0; waa = '0; wda = '0;
        web = 1'b0; wab = '0; wdb = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    vec_t tv [18];

    initial begin
        // Port order inside packed fields is {p3, p2, p1, p0}.
        tv[0]  = mk(4'h0, 20'h0,          1, 5'd5, 32'h1111,     1, 5'd5, 32'h2222, 0, 5'd0,
                    4'h0, 128'h0, 4'h0, 32'h0);
        tv[1]  = mk(4'hf, {4{5'd5}},      0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0,
                    4'hf, {4{32'h2222}}, 4'h0, 32'h0);
        tv[2]  = mk(4'hf, {4{5'd7}},      1, 5'd7, 32'hA5A5,     0, 5'd0, 32'h0,    0, 5'd0,
                    4'hf, BYP ? {4{32'hA5A5}} : 128'h0, 4'h0, 32'h0);
        tv[3]  = mk(4'hf, {4{5'd7}},      0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0,
                    4'hf, {4{32'hA5A5}}, 4'h0, 32'h0);
        tv[4]  = mk(4'h0, 20'h0,          1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'h0,    1, 5'd0,
                    4'h0, {4{32'hA5A5}}, 4'h0, 32'h0);
        tv[5]  = mk(4'hf, {4{5'd0}},      0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0,
                    4'hf, 128'h0, 4'h0, 32'h0);
        tv[6]  = mk(4'h0, 20'h0,          0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd3,
                    4'h0, 128'h0, 4'h0, 32'h8);
        tv[7]  = mk(4'hf, {4{5'd3}},      0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0,
                    4'hf, 128'h0, 4'hf, 32'h8);
        tv[8]  = mk(4'hf, {4{5'd3}},      1, 5'd3, 32'h3333,     0, 5'd0, 32'h0,    1, 5'd3,
                    4'hf, BYP ? {4{32'h3333}} : 128'h0, 4'hf, 32'h8);
        tv[9]  = mk(4'hf, {4{5'd3}},      0, 5'd0, 32'h0,        1, 5'd3, 32'h4444, 0, 5'd0,
                    4'hf, BYP ? {4{32'h4444}} : {4{32'h3333}}, BYP ? 4'h0 : 4'hf, 32'h0);
        tv[10] = mk(4'hf, {4{5'd3}},      0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0,
                    4'hf, {4{32'h4444}}, 4'h0, 32'h0);
        tv[11] = mk(4'h0, 20'h0,          0, 5'd0, 32'h0,        1, 5'd9, 32'h55,   0, 5'd0,
                    4'h0, {4{32'h4444}}, 4'h0, 32'h0);
        tv[12] = mk(4'ha, {4{5'd9}},      0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0,
                    4'ha, {32'h55, 32'h4444, 32'h55, 32'h4444}, 4'h0, 32'h0);
        tv[13] = mk(4'hf, {5'd9, 5'd3, 5'd5, 5'd7}, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0,
                    4'hf, {32'h55, 32'h4444, 32'h2222, 32'hA5A5}, 4'h0, 32'h0);
        tv[14] = mk(4'h0, 20'h0,          1, 5'd10, 32'hAAAA,    1, 5'd11, 32'hBBBB, 0, 5'd0,
                    4'h0, {32'h55, 32'h4444, 32'h2222, 32'hA5A5}, 4'h0, 32'h0);
        tv[15] = mk(4'hf, {5'd0, 5'd0, 5'd11, 5'd10}, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0,
                    4'hf, {32'h0, 32'h0, 32'hBBBB, 32'hAAAA}, 4'h0, 32'h0);
        tv[16] = mk(4'hf, {4{5'd12}},     1, 5'd12, 32'h1212,    1, 5'd12, 32'h3434, 0, 5'd0,
                    4'hf, BYP ? {4{32'h3434}} : 128'h0, 4'h0, 32'h0);
        tv[17] = mk(4'hf, {4{5'd12}},     0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0,
                    4'hf, {4{32'h3434}}, 4'h0, 32'h0);

        idle_inputs();
        rst = 1'b1;
        #12;
        chk("reset_vld",  rd_valid, 4'h0);
        chk("reset_rd",   rd,       128'h0);
        chk("reset_pd",   rd_pend,  4'h0);
        chk("reset_pend", pend,     32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 18; k++) begin
            re = tv[k].re; ra = tv[k].ra;
            wea = tv[k].wea; waa = tv[k].waa; wda = tv[k].wda;
            web = tv[k].web; wab = tv[k].wab; wdb = tv[k].wdb;
            rsv_en = tv[k].rsv_en; rsv_addr = tv[k].rsv_addr;
            @(negedge clk);
            chk($sformatf("v%0d_vld", k),  rd_valid, tv[k].x_vld);
            chk($sformatf("v%0d_rd", k),   rd,       tv[k].x_rd);
            chk($sformatf("v%0d_pd", k),   rd_pend,  tv[k].x_pd);
            chk($sformatf("v%0d_pend", k), pend,     tv[k].x_pend);
        end

        // Dirty the file and scoreboard, then reset asynchronously mid-cycle while reads are in flight.
        idle_inputs();
        wea = 1'b1; waa = 5'd2; wda = 32'h7777;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        re = 4'hf; ra = {4{5'd3}};
        @(posedge clk);
        #2;
        chk("pre_rst_pend", pend, 32'h10);
        rst = 1'b1;
        #1;
        chk("rst_async_vld",  rd_valid, 4'h0);
        chk("rst_async_rd",   rd,       128'h0);
        chk("rst_async_pd",   rd_pend,  4'h0);
        chk("rst_async_pend", pend,     32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_vld", rd_valid, 4'h0);
        chk("rst_hold_rd",  rd,       128'h0);
        rst = 1'b0;
        idle_inputs();

        for (int k = 1; k < 32; k++) begin
            logic [4:0] a;
            a = 5'(k);
            re = 4'hf;
            ra = {4{a}};
            @(negedge clk);
            chk($sformatf("clr_r%0d_vld", k), rd_valid, 4'hf);
            chk($sformatf("clr_r%0d_rd", k),  rd,       128'h0);
            chk($sformatf("clr_r%0d_pd", k),  rd_pend,  4'h0);
        end
        chk("clr_pend", pend, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
